// File: rtl/xdma_multi_finish_tracker.sv
// Finish tracker for concurrent XDMA chain writes: a slot CAM for first/middle
// hops matched by DMA ID, plus a forward FIFO of finishes owed to previous hops.
module xdma_multi_finish_tracker #(
  parameter int unsigned NumSlots  = 4,
  parameter int unsigned FwdDepth  = 4,
  parameter int unsigned IdWidth   = 8,
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned CntWidth  = $clog2(NumSlots + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 alloc_valid_i,
  output logic                 alloc_ready_o,
  input  logic                 alloc_first_i,
  input  logic [IdWidth-1:0]   alloc_id_i,
  input  logic [AddrWidth-1:0] alloc_addr_i,
  input  logic                 last_done_valid_i,
  output logic                 last_done_ready_o,
  input  logic [IdWidth-1:0]   last_done_id_i,
  input  logic [AddrWidth-1:0] last_done_addr_i,
  input  logic                 read_done_valid_i,
  input  logic [IdWidth-1:0]   read_done_id_i,
  input  logic                 from_remote_finish_valid_i,
  output logic                 from_remote_finish_ready_o,
  input  logic [IdWidth-1:0]   from_remote_finish_id_i,
  output logic                 to_remote_finish_valid_o,
  input  logic                 to_remote_finish_ready_i,
  output logic [AddrWidth-1:0] remote_addr_o,
  output logic [IdWidth-1:0]   from_remote_dma_id_o,
  output logic                 xdma_finish_o,
  output logic [IdWidth-1:0]   xdma_finish_id_o,
  output logic                 xdma_write_finish_o,
  output logic                 unexpected_finish_o,
  output logic [CntWidth-1:0]  outstanding_o
);

  localparam int unsigned SlotIdxW = (NumSlots > 1) ? $clog2(NumSlots) : 1;
  localparam int unsigned PtrW     = (FwdDepth > 1) ? $clog2(FwdDepth) : 1;
  localparam int unsigned FcntW    = $clog2(FwdDepth + 1);
  localparam logic [PtrW-1:0]  PtrLast = PtrW'(FwdDepth - 1);
  localparam logic [FcntW-1:0] FcntMax = FcntW'(FwdDepth);

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
  } fwd_t;

  logic [NumSlots-1:0]  slot_valid_q;
  logic [NumSlots-1:0]  slot_first_q;
  logic [IdWidth-1:0]   slot_id_q   [NumSlots];
  logic [AddrWidth-1:0] slot_addr_q [NumSlots];

  fwd_t            fifo_q [FwdDepth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FcntW-1:0] fcnt_q;

  logic                free_found, hit;
  logic [SlotIdxW-1:0] free_idx, hit_idx;
  logic                hit_first, fifo_full, fifo_empty;
  logic                alloc_hs, fin_hs, first_hs, mid_hs, last_hs, push, pop;
  fwd_t                push_data;

  // Downward scans so the last assignment is the lowest qualifying index.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    free_found = 1'b0;
    free_idx   = '0;
    hit        = 1'b0;
    hit_idx    = '0;
    for (int i = NumSlots - 1; i >= 0; i--) begin
      if (!slot_valid_q[i]) begin
        free_found = 1'b1;
        free_idx   = SlotIdxW'(i);
      end
      if (slot_valid_q[i] && (slot_id_q[i] == from_remote_finish_id_i)) begin
        hit     = 1'b1;
        hit_idx = SlotIdxW'(i);
      end
    end
  end

  assign hit_first  = hit && slot_first_q[hit_idx];
  assign fifo_full  = (fcnt_q == FcntMax);
  assign fifo_empty = (fcnt_q == '0);

  always_comb begin
    from_remote_finish_ready_o = 1'b1;
    if (hit) begin
      if (hit_first) from_remote_finish_ready_o = !read_done_valid_i;
      else           from_remote_finish_ready_o = !fifo_full && !last_done_valid_i;
    end
  end

  assign alloc_ready_o     = free_found;
  assign last_done_ready_o = !fifo_full;

  assign alloc_hs = alloc_valid_i && free_found;
  assign fin_hs   = from_remote_finish_valid_i && from_remote_finish_ready_o;
  assign first_hs = fin_hs && hit && hit_first;
  assign mid_hs   = fin_hs && hit && !hit_first;
  assign last_hs  = last_done_valid_i && last_done_ready_o;
  assign push     = last_hs || mid_hs;
  assign pop      = !fifo_empty && to_remote_finish_ready_i;

  assign push_data = last_hs ? fwd_t'{id: last_done_id_i, addr: last_done_addr_i}
                             : fwd_t'{id: slot_id_q[hit_idx], addr: slot_addr_q[hit_idx]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_valid_q <= '0;
    end else begin
      for (int i = 0; i < NumSlots; i++) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
        if (alloc_hs && (free_idx == SlotIdxW'(i)))      slot_valid_q[i] <= 1'b1;
        else if (fin_hs && hit && (hit_idx == SlotIdxW'(i))) slot_valid_q[i] <= 1'b0;
      end
    end
  end

  // NOTE: slot payload is not reset; it is only observed while its valid bit is set.
  always_ff @(posedge clk_i) begin
    if (alloc_hs) begin
      slot_first_q[free_idx] <= alloc_first_i;
      slot_id_q[free_idx]    <= alloc_id_i;
      slot_addr_q[free_idx]  <= alloc_addr_i;
    end
  end

  // FIFO storage is reset because its head drives outputs that must read 0 after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FwdDepth; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fcnt_q   <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= push_data;
        wr_ptr_q         <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  assign to_remote_finish_valid_o = !fifo_empty;
  assign remote_addr_o            = fifo_q[rd_ptr_q].addr;
  assign from_remote_dma_id_o     = fifo_q[rd_ptr_q].id;

  // Read completions take the frontend port ahead of first-hop finishes.
  assign xdma_finish_o       = read_done_valid_i || first_hs;
  assign xdma_finish_id_o    = read_done_valid_i ? read_done_id_i
                             : (first_hs ? slot_id_q[hit_idx] : '0);
  assign xdma_write_finish_o = first_hs || pop;
  assign unexpected_finish_o = fin_hs && !hit;

  always_comb begin
    outstanding_o = '0;
    for (int i = 0; i < NumSlots; i++) begin
      if (slot_valid_q[i]) outstanding_o = outstanding_o + CntWidth'(1);
    end
  end

endmodule

// File: tb/tb_xdma_multi_finish_tracker.sv
// Bench for xdma_multi_finish_tracker: directed scenarios plus random traffic,
// checked against a queue-based reference model and a decoupled output monitor.
module tb_xdma_multi_finish_tracker;

  localparam int NS = 4;
  localparam int FD = 2;
  localparam int IW = 8;
  localparam int AW = 48;
  localparam int CW = $clog2(NS + 1);

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          alloc_valid_i = 0, alloc_first_i = 0;
  logic [IW-1:0] alloc_id_i = '0;
  logic [AW-1:0] alloc_addr_i = '0;
  logic          last_done_valid_i = 0;
  logic [IW-1:0] last_done_id_i = '0;
  logic [AW-1:0] last_done_addr_i = '0;
  logic          read_done_valid_i = 0;
  logic [IW-1:0] read_done_id_i = '0;
  logic          from_remote_finish_valid_i = 0;
  logic [IW-1:0] from_remote_finish_id_i = '0;
  logic          to_remote_finish_ready_i = 0;

  logic          alloc_ready_o, last_done_ready_o, from_remote_finish_ready_o;
  logic          to_remote_finish_valid_o;
  logic [AW-1:0] remote_addr_o;
  logic [IW-1:0] from_remote_dma_id_o, xdma_finish_id_o;
  logic          xdma_finish_o, xdma_write_finish_o, unexpected_finish_o;
  logic [CW-1:0] outstanding_o;

  xdma_multi_finish_tracker #(
    .NumSlots(NS), .FwdDepth(FD), .IdWidth(IW), .AddrWidth(AW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alloc_valid_i(alloc_valid_i), .alloc_ready_o(alloc_ready_o),
    .alloc_first_i(alloc_first_i), .alloc_id_i(alloc_id_i), .alloc_addr_i(alloc_addr_i),
    .last_done_valid_i(last_done_valid_i), .last_done_ready_o(last_done_ready_o),
    .last_done_id_i(last_done_id_i), .last_done_addr_i(last_done_addr_i),
    .read_done_valid_i(read_done_valid_i), .read_done_id_i(read_done_id_i),
    .from_remote_finish_valid_i(from_remote_finish_valid_i),
    .from_remote_finish_ready_o(from_remote_finish_ready_o),
    .from_remote_finish_id_i(from_remote_finish_id_i),
    .to_remote_finish_valid_o(to_remote_finish_valid_o),
    .to_remote_finish_ready_i(to_remote_finish_ready_i),
    .remote_addr_o(remote_addr_o), .from_remote_dma_id_o(from_remote_dma_id_o),
    .xdma_finish_o(xdma_finish_o), .xdma_finish_id_o(xdma_finish_id_o),
    .xdma_write_finish_o(xdma_write_finish_o), .unexpected_finish_o(unexpected_finish_o),
    .outstanding_o(outstanding_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: slot table as plain records, forward FIFO as a queue.
  typedef struct {
    bit            v;
    bit            first;
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
  } mslot_t;
  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
  } fwd_t;

  mslot_t        m_slot [NS];
  fwd_t          m_fifo [$];
  fwd_t          exp_fwd[$];
  logic [IW-1:0] exp_fin[$];
  bit            m_fin_hs;

  task automatic model_reset();
    for (int i = 0; i < NS; i++) m_slot[i].v = 0;
    m_fifo.delete();
    exp_fwd.delete();
    exp_fin.delete();
  endtask

  // Evaluated at the falling edge, with inputs stable for the current cycle.
  task automatic model_eval();
    int   free_i = -1;
    int   hit_i  = -1;
    int   nvalid = 0;
    bit   hit_first = 0;
    bit   fin_rdy, last_rdy, last_hs, alloc_hs, pop, xfin, wfin, unexp;
    fwd_t e;
    for (int i = 0; i < NS; i++) begin
      if (!m_slot[i].v && free_i < 0) free_i = i;
      if (m_slot[i].v && m_slot[i].id == from_remote_finish_id_i && hit_i < 0) hit_i = i;
      if (m_slot[i].v) nvalid++;
    end
    if (hit_i >= 0) hit_first = m_slot[hit_i].first;
    last_rdy = (m_fifo.size() < FD);
    if (hit_i < 0)      fin_rdy = 1;
    else if (hit_first) fin_rdy = !read_done_valid_i;
    else                fin_rdy = last_rdy && !last_done_valid_i;
    m_fin_hs = from_remote_finish_valid_i && fin_rdy;
    last_hs  = last_done_valid_i && last_rdy;
    alloc_hs = alloc_valid_i && (free_i >= 0);
    pop      = (m_fifo.size() > 0) && to_remote_finish_ready_i;
    xfin     = read_done_valid_i || (m_fin_hs && hit_first);
    wfin     = (m_fin_hs && hit_first) || pop;
    unexp    = m_fin_hs && (hit_i < 0);

    check("alloc_ready", alloc_ready_o, free_i >= 0);
    check("last_ready", last_done_ready_o, last_rdy);
    check("fin_ready", from_remote_finish_ready_o, fin_rdy);
    check("to_valid", to_remote_finish_valid_o, m_fifo.size() > 0);
    check("outstanding", outstanding_o, nvalid);
    check("xdma_finish", xdma_finish_o, xfin);
    check("write_finish", xdma_write_finish_o, wfin);
    check("unexpected", unexpected_finish_o, unexp);
    if (m_fifo.size() > 0) check("head", {from_remote_dma_id_o, remote_addr_o}, {m_fifo[0].id, m_fifo[0].addr});

    if (xfin) exp_fin.push_back(read_done_valid_i ? read_done_id_i : m_slot[hit_i].id);
    if (pop) e = m_fifo.pop_front();
    if (last_hs) begin
      e.id = last_done_id_i; e.addr = last_done_addr_i;
      m_fifo.push_back(e); exp_fwd.push_back(e);
    end else if (m_fin_hs && hit_i >= 0 && !hit_first) begin
      e.id = m_slot[hit_i].id; e.addr = m_slot[hit_i].addr;
      m_fifo.push_back(e); exp_fwd.push_back(e);
    end
    if (m_fin_hs && hit_i >= 0) m_slot[hit_i].v = 0;
    if (alloc_hs) begin
      m_slot[free_i].v     = 1;
      m_slot[free_i].first = alloc_first_i;
      m_slot[free_i].id    = alloc_id_i;
      m_slot[free_i].addr  = alloc_addr_i;
    end
  endtask

  // Monitor: consumes expected responses whenever the DUT presents one.
  always @(negedge clk_i) begin
    fwd_t e;
    #1;
    if (rst_ni) begin
      if (xdma_finish_o) begin
        if (exp_fin.size() == 0) begin
          total++; bad++;
          $display("FAIL fin_extra: got id %0h expected no pulse", xdma_finish_id_o);
        end else check("fin_id", xdma_finish_id_o, exp_fin.pop_front());
      end else if (exp_fin.size() > 0) begin
        total++; bad++;
        $display("FAIL fin_missing: got no pulse expected id %0h", exp_fin[0]);
        exp_fin.delete();
      end
      if (to_remote_finish_valid_o && to_remote_finish_ready_i) begin
        if (exp_fwd.size() == 0) begin
          total++; bad++;
          $display("FAIL fwd_extra: got %0h expected no entry", from_remote_dma_id_o);
        end else begin
          e = exp_fwd.pop_front();
          check("fwd_entry", {from_remote_dma_id_o, remote_addr_o}, {e.id, e.addr});
        end
      end
    end
  end

  task automatic half();
    @(negedge clk_i);
  endtask
  task automatic fin_cyc();
    model_eval();
    @(posedge clk_i);
    #1;
  endtask
  task automatic step();
    half();
    fin_cyc();
  endtask
  task automatic idle();
    alloc_valid_i = 0; last_done_valid_i = 0; read_done_valid_i = 0;
    from_remote_finish_valid_i = 0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_outstanding"}, outstanding_o, 0);
    check({tag, "_alloc_ready"}, alloc_ready_o, 1);
    check({tag, "_last_ready"}, last_done_ready_o, 1);
    check({tag, "_fin_ready"}, from_remote_finish_ready_o, 1);
    check({tag, "_to_valid"}, to_remote_finish_valid_o, 0);
    check({tag, "_xdma_finish"}, xdma_finish_o, 0);
    check({tag, "_write_finish"}, xdma_write_finish_o, 0);
    check({tag, "_addr"}, remote_addr_o, 0);
  endtask

  initial begin
    int oo_ids[4] = '{3, 5, 7, 9};
    int waited;
    bit accepted;

    // Reset
    #2 rst_ni = 0;
    #1 check_reset_values("rst");
    model_reset();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1;

    // Out-of-order first-hop finish
    alloc_first_i = 1;
    foreach (oo_ids[k]) begin
      alloc_valid_i = 1; alloc_id_i = IW'(oo_ids[k]); alloc_addr_i = '0;
      step();
    end
    idle();
    half(); check("oo_full", alloc_ready_o, 0); fin_cyc();
    from_remote_finish_valid_i = 1; from_remote_finish_id_i = 8'h07;
    half();
    check("oo_finish", xdma_finish_o, 1);
    check("oo_finish_id", xdma_finish_id_o, 8'h07);
    check("oo_wfinish", xdma_write_finish_o, 1);
    fin_cyc(); idle();
    half(); check("oo_outstanding", outstanding_o, 3); check("oo_ready", alloc_ready_o, 1); fin_cyc();
    foreach (oo_ids[k]) begin
      if (oo_ids[k] != 7) begin
        from_remote_finish_valid_i = 1; from_remote_finish_id_i = IW'(oo_ids[k]);
        step();
      end
    end
    idle();

    // Middle hop
    to_remote_finish_ready_i = 0;
    alloc_valid_i = 1; alloc_first_i = 0; alloc_id_i = 8'h12; alloc_addr_i = 48'h1000;
    step(); idle();
    from_remote_finish_valid_i = 1; from_remote_finish_id_i = 8'h12;
    step(); idle();
    repeat (3) begin
      half();
      check("mid_valid", to_remote_finish_valid_o, 1);
      check("mid_addr", remote_addr_o, 48'h1000);
      check("mid_id", from_remote_dma_id_o, 8'h12);
      fin_cyc();
    end
    to_remote_finish_ready_i = 1;
    half(); check("mid_pop_pulse", xdma_write_finish_o, 1); fin_cyc();
    to_remote_finish_ready_i = 0;
    half(); check("mid_empty", to_remote_finish_valid_o, 0); fin_cyc();

    // Read vs first-hop collision
    alloc_valid_i = 1; alloc_first_i = 1; alloc_id_i = 8'h04;
    step(); idle();
    read_done_valid_i = 1; read_done_id_i = 8'h08;
    from_remote_finish_valid_i = 1; from_remote_finish_id_i = 8'h04;
    half(); check("col_read_id", xdma_finish_id_o, 8'h08); check("col_blocked", from_remote_finish_ready_o, 0); fin_cyc();
    read_done_valid_i = 0;
    half(); check("col_accept", from_remote_finish_ready_o, 1); check("col_fin_id", xdma_finish_id_o, 8'h04); fin_cyc();
    idle();

    // FIFO full
    to_remote_finish_ready_i = 0;
    last_done_valid_i = 1; last_done_id_i = 8'hA1; last_done_addr_i = 48'hA000; step();
    last_done_id_i = 8'hA2; last_done_addr_i = 48'hB000; step();
    idle();
    half(); check("full_last_ready", last_done_ready_o, 0); fin_cyc();
    alloc_valid_i = 1; alloc_first_i = 0; alloc_id_i = 8'h33; alloc_addr_i = 48'hC000;
    step(); idle();
    from_remote_finish_valid_i = 1; from_remote_finish_id_i = 8'h33;
    half(); check("full_fin_ready", from_remote_finish_ready_o, 0); fin_cyc();
    to_remote_finish_ready_i = 1;
    waited = 0; accepted = 0;
    while (!accepted && waited < 10) begin
      step(); waited++; accepted = m_fin_hs;
    end
    check("full_push_accepted", accepted, 1);
    check("full_wait_cycles", waited, 2);
    idle();
    repeat (3) step();
    to_remote_finish_ready_i = 0;

    // Unexpected finish
    from_remote_finish_valid_i = 1; from_remote_finish_id_i = 8'h55;
    half();
    check("unexp_pulse", unexpected_finish_o, 1);
    check("unexp_xfin", xdma_finish_o, 0);
    check("unexp_wfin", xdma_write_finish_o, 0);
    fin_cyc(); idle();
    half(); check("unexp_once", unexpected_finish_o, 0); check("unexp_outstanding", outstanding_o, 0); fin_cyc();

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      alloc_valid_i              = ($urandom_range(0, 2) == 0);
      alloc_first_i              = $urandom_range(0, 1);
      alloc_id_i                 = IW'($urandom_range(0, 7));
      alloc_addr_i               = {$urandom, $urandom};
      last_done_valid_i          = ($urandom_range(0, 4) == 0);
      last_done_id_i             = IW'($urandom);
      last_done_addr_i           = {$urandom, $urandom};
      read_done_valid_i          = ($urandom_range(0, 5) == 0);
      read_done_id_i             = IW'($urandom);
      from_remote_finish_valid_i = ($urandom_range(0, 1) == 0);
      from_remote_finish_id_i    = IW'($urandom_range(0, 7));
      to_remote_finish_ready_i   = ($urandom_range(0, 2) != 0);
      step();
    end
    idle();

    // Reset in the middle of operation
    to_remote_finish_ready_i = 0;
    last_done_valid_i = 1; last_done_id_i = 8'h77; last_done_addr_i = 48'h7700;
    alloc_valid_i = 1; alloc_first_i = 1; alloc_id_i = 8'h66;
    step(); idle();
    half(); check("pre_rst_valid", to_remote_finish_valid_o, 1); fin_cyc();
    #2 rst_ni = 0;
    #1 check_reset_values("midrst");
    model_reset();
    @(posedge clk_i);
    #1 rst_ni = 1;
    half(); check("post_rst_outstanding", outstanding_o, 0); fin_cyc();

    // Drain and confirm the scoreboard saw everything
    to_remote_finish_ready_i = 1;
    repeat (4) step();
    check("drain_fwd", exp_fwd.size(), 0);
    check("drain_fin", exp_fin.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
